// File: rtl/lab3_pkg.sv
// -----------------------------------------------------------------------------
// lab3_pkg
// Shared definitions for the rr_encoder_4to2 round-robin encoder.
//   NREQ      : number of request lines the encoder is built for (4)
//   state_t   : grant FSM states (IDLE = no grant held, HOLD = grant presented)
//   idx_inc() : next round-robin pointer after a granted index (wraps 3 -> 0)
// -----------------------------------------------------------------------------
package lab3_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Pointer moves one past the line just served; 2-bit arithmetic gives the wrap.
    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_encoder_4to2_if.sv
// -----------------------------------------------------------------------------
// rr_encoder_4to2_if
// Bundles the request/enable/ready inputs and the index/valid outputs of the
// round-robin encoder.
//   master : drives d0..d3, e, rdy; observes a1, a0, v (request source/consumer)
//   slave  : observes d0..d3, e, rdy; drives a1, a0, v (the encoder side)
// -----------------------------------------------------------------------------
interface rr_encoder_4to2_if ();

    logic d0;
    logic d1;
    logic d2;
    logic d3;
    logic e;
    logic rdy;
    logic a1;
    logic a0;
    logic v;

    modport master (
        output d0, d1, d2, d3, e, rdy,
        input  a1, a0, v
    );

    modport slave (
        input  d0, d1, d2, d3, e, rdy,
        output a1, a0, v
    );

endinterface

// File: rtl/rr_encoder_4to2_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request in
// the search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   req_i [3:0] : request bits, bit n = line n
//   ptr_i [1:0] : highest-priority line for this search
//   idx_o [1:0] : selected line (equals ptr_i when nothing is requesting)
//   any_o       : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick
    import lab3_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [1:0]      idx_o,
    output logic            any_o
);

    always_comb begin
        idx_o = ptr_i;
        any_o = |req_i;
        // Walk from lowest to highest priority so the last hit wins, leaving
        // the line closest to ptr_i on idx_o.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[ptr_i + 2'(k)]) begin
                idx_o = ptr_i + 2'(k);
            end
        end
    end

endmodule

// File: rtl/rr_encoder_4to2.sv
// -----------------------------------------------------------------------------
// rr_encoder_4to2
// Registered 4-to-2 round-robin priority encoder with a valid/ready output.
// A grant is captured from d0..d3 when enabled, held on a1/a0 with v=1 until
// the consumer accepts it with rdy, and the next grant can be captured on the
// same edge as the accept.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   d0..d3     : request lines, level-sensitive
//   e          : enable for capturing a new grant
//   rdy        : consumer ready; v & rdy at an edge is a transfer
//   a1, a0     : registered granted index (a1 = MSB)
//   v          : registered valid for a1/a0
// -----------------------------------------------------------------------------
module rr_encoder_4to2
    import lab3_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic e,
    input  logic rdy,
    output logic a1,
    output logic a0,
    output logic v
);

    generate
        if (NREQ != lab3_pkg::NREQ) begin : g_bad_nreq
            $error("rr_encoder_4to2 is built for exactly 4 request lines");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic       v_q, v_d;

    logic [3:0] req;
    logic       xfer;
    logic [1:0] pick_ptr;
    logic [1:0] pick_idx;
    logic       pick_any;

    assign req  = {d3, d2, d1, d0};
    assign xfer = (state_q == HOLD) && rdy;

    // On a transfer the search must already use the advanced pointer so a
    // back-to-back grant respects the rotation without waiting a cycle.
    assign pick_ptr = xfer ? idx_inc(idx_q) : ptr_q;

    rr_pick u_pick (
        .req_i (req),
        .ptr_i (pick_ptr),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (e && pick_any) begin
                    idx_d   = pick_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Without rdy the grant is frozen, whatever the requests do.
                if (rdy) begin
                    ptr_d = idx_inc(idx_q);
                    if (e && pick_any) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        v_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            v_q     <= v_d;
        end
    end

    assign a1 = idx_q[1];
    assign a0 = idx_q[0];
    assign v  = v_q;

endmodule

// File: tb/tb_rr_encoder_4to2.sv
// -----------------------------------------------------------------------------
// tb_rr_encoder_4to2
// Directed scoreboard bench: stimulus pushes the hand-computed grant index of
// every expected transfer; a monitor pops and compares on each v & rdy.
// -----------------------------------------------------------------------------
module tb_rr_encoder_4to2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rr_encoder_4to2_if bus ();

    rr_encoder_4to2 #(.NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .d0    (bus.d0),
        .d1    (bus.d1),
        .d2    (bus.d2),
        .d3    (bus.d3),
        .e     (bus.e),
        .rdy   (bus.rdy),
        .a1    (bus.a1),
        .a0    (bus.a0),
        .v     (bus.v)
    );

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];

    // Monitor: every cycle where v and rdy are both high is a transfer.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.v === 1'b1 && bus.rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got index %0d, required no transfer",
                         {bus.a1, bus.a0});
            end else begin
                logic [1:0] want;
                want = exp_q.pop_front();
                if ({bus.a1, bus.a0} !== want) begin
                    errors++;
                    $display("FAIL xfer_index: got %0d, required %0d",
                             {bus.a1, bus.a0}, want);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] d);
        bus.d0 = d[0];
        bus.d1 = d[1];
        bus.d2 = d[2];
        bus.d3 = d[3];
    endtask

    // Compares {v, a1, a0} against the required value.
    task automatic chk(input string name, input logic [2:0] want);
        checks++;
        if ({bus.v, bus.a1, bus.a0} !== want) begin
            errors++;
            $display("FAIL %s: got v,a1a0=%b, required %b", name,
                     {bus.v, bus.a1, bus.a0}, want);
        end
    endtask

    task automatic chk_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected transfers never seen, required 0",
                     name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic rst_pulse();
        reset   = 1'b1;
        set_d(4'b0000);
        bus.e   = 1'b0;
        bus.rdy = 1'b0;
        step(1);
        reset   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        set_d(4'b0000);
        bus.e   = 1'b0;
        bus.rdy = 1'b0;
        step(2);
        chk("reset_state", 3'b000);
        reset = 1'b0;

        // d=1010: grants 1, 3, 1
        set_d(4'b1010); bus.e = 1'b1; bus.rdy = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
        step(4);
        rst_pulse();
        chk_empty("seq_1010");

        // All requesting: 0,1,2,3,0 back to back
        set_d(4'b1111); bus.e = 1'b1; bus.rdy = 1'b1;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        step(6);
        rst_pulse();
        chk_empty("seq_all");

        // Hold index 2 for 5 cycles while d2 drops and d0 rises
        set_d(4'b0100); bus.e = 1'b1; bus.rdy = 1'b0;
        step(1);
        set_d(4'b0001);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("hold_stable", 3'b110);
        end
        exp_q.push_back(2'd2); exp_q.push_back(2'd0);
        bus.rdy = 1'b1;
        step(2);
        rst_pulse();
        chk_empty("hold_release");

        // Enable low blocks capture; rdy in IDLE does nothing
        set_d(4'b1000); bus.e = 1'b0; bus.rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("e_low_idle", 3'b000);
        end
        exp_q.push_back(2'd3);
        bus.e = 1'b1;
        step(1);
        chk("e_rise", 3'b111);
        step(1);
        rst_pulse();
        chk_empty("e_rise_xfer");

        // Reset during HOLD at index 3 discards the grant
        set_d(4'b1000); bus.e = 1'b1; bus.rdy = 1'b0;
        step(1);
        chk("hold_3", 3'b111);
        reset = 1'b1;
        set_d(4'b1111);
        step(1);
        chk("reset_in_hold", 3'b000);
        reset   = 1'b0;
        bus.rdy = 1'b1;
        exp_q.push_back(2'd0);
        step(2);
        rst_pulse();
        chk_empty("after_reset_grant");

        // Only d3: repeated grants of 3 with pointer wrap, then all lines -> 0
        set_d(4'b1000); bus.e = 1'b1; bus.rdy = 1'b1;
        exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        step(4);
        set_d(4'b1111);
        exp_q.push_back(2'd0);
        step(2);
        rst_pulse();
        chk_empty("d3_wrap");

        // Transfer with e=0 returns to IDLE, index retained
        set_d(4'b0010); bus.e = 1'b1; bus.rdy = 1'b1;
        exp_q.push_back(2'd1);
        step(1);
        bus.e = 1'b0;
        step(2);
        chk("idle_after_xfer", 3'b001);
        rst_pulse();
        chk_empty("xfer_to_idle");

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
